// File: rtl/dcs_gram_attn_core.sv
// dcs_gram_attn_core: streams X, builds H = X*X^T, optional row-average threshold, returns y = H*w.
module dcs_gram_attn_core #(
  parameter int N  = 8,
  parameter int L  = 16,
  parameter int DW = 8,
  parameter int OW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          i_ready,
  input  logic          mode,
  input  logic          w_valid,
  input  logic [DW-1:0] w_data,
  output logic          w_ready,
  output logic          o_valid,
  output logic [OW-1:0] o_data,
  input  logic          o_ready,
  output logic          busy
);
  localparam int RW = $clog2(N);
  localparam int CW = (L > 1) ? $clog2(L) : 1;
  localparam int HW = 2 * DW + $clog2(L);
  localparam int SW = HW + RW;
  localparam int PW = HW + DW;

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, THRESH, WGT, OUT} state_t;

  state_t        r_state, w_next;
  logic [DW-1:0] r_x [N][L];
  logic [HW-1:0] r_h [N][N];
  logic [OW-1:0] r_y [N];
  logic [RW-1:0] r_row, r_pr, r_k, r_oi;
  logic [CW-1:0] r_col, r_pc;
  logic          r_pv, r_mode;
  logic [HW-1:0] w_avg [N];
  logic [PW-1:0] w_prod [N];
  logic [SW-1:0] w_sum;
  logic          w_xa, w_wa, w_oa, w_last_x;

  assign i_ready  = (r_state == IDLE) || (r_state == LOAD);
  assign w_ready  = r_state == WGT;
  assign o_valid  = r_state == OUT;
  assign o_data   = o_valid ? r_y[r_oi] : '0;
  assign busy     = r_state != IDLE;
  assign w_xa     = i_valid && i_ready;
  assign w_wa     = w_valid && w_ready;
  assign w_oa     = o_valid && o_ready;
  assign w_last_x = (r_row == RW'(N - 1)) && (r_col == CW'(L - 1));

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_xa ? LOAD : IDLE;
      LOAD:    w_next = (w_xa && w_last_x) ? FLUSH : LOAD;
      FLUSH:   w_next = THRESH;
      THRESH:  w_next = WGT;
      WGT:     w_next = (w_wa && r_k == RW'(N - 1)) ? OUT : WGT;
      OUT:     w_next = (w_oa && r_oi == RW'(N - 1)) ? IDLE : OUT;
      default: w_next = IDLE;
    endcase
  end

  // row average is the row sum shifted down by log2(N); it never exceeds the row maximum
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = '0;
      for (int j = 0; j < N; j++) w_sum = w_sum + SW'(r_h[i][j]);
      w_avg[i]  = HW'(w_sum >> RW);
      w_prod[i] = PW'(r_h[i][r_k]) * PW'(w_data);
    end
  end

  always_ff @(posedge clk)
    if (w_xa) r_x[r_row][r_col] <= i_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h    <= '{default: '0};
      r_y    <= '{default: '0};
      r_row  <= '0;
      r_col  <= '0;
      r_pr   <= '0;
      r_pc   <= '0;
      r_k    <= '0;
      r_oi   <= '0;
      r_pv   <= 1'b0;
      r_mode <= 1'b0;
    end else begin
      r_pv <= w_xa;
      if (w_xa) begin
        r_pr  <= r_row;
        r_pc  <= r_col;
        r_col <= (r_col == CW'(L - 1)) ? '0 : r_col + CW'(1);
        if (r_col == CW'(L - 1)) r_row <= r_row + RW'(1);
      end
      if (w_xa && r_state == IDLE) r_mode <= mode;
      // the beat registered last cycle is already in r_x, so its row pairs with all earlier rows
      if (r_pv)
        for (int a = 0; a < N; a++)
          for (int b = 0; b < N; b++)
            if ((RW'(a) == r_pr && RW'(b) <= r_pr) || (RW'(b) == r_pr && RW'(a) <= r_pr))
              r_h[a][b] <= r_h[a][b] + HW'(r_x[a][r_pc]) * HW'(r_x[b][r_pc]);
      if (r_state == THRESH && !r_mode)
        for (int a = 0; a < N; a++)
          for (int b = 0; b < N; b++)
            r_h[a][b] <= (r_h[a][b] < w_avg[a]) ? '0 : r_h[a][b];
      if (w_wa) begin
        for (int a = 0; a < N; a++) r_y[a] <= r_y[a] + OW'(w_prod[a]);
        r_k <= r_k + RW'(1);
      end
      if (w_oa) begin
        r_oi <= r_oi + RW'(1);
        if (r_oi == RW'(N - 1)) begin
          r_h <= '{default: '0};
          r_y <= '{default: '0};
        end
      end
    end
  end
endmodule

// File: tb/tb_dcs_gram_attn_core.sv
// tb_dcs_gram_attn_core: randomized frames against a plain-arithmetic Gram/attention model, scoreboarded outputs.
module tb_dcs_gram_attn_core;
  localparam int N = 8;
  localparam int L = 16;

  logic        clk = 0, rst = 1;
  logic        i_valid = 0, mode = 0, w_valid = 0, o_ready = 0;
  logic [7:0]  i_data = 0, w_data = 0;
  logic        i_ready, w_ready, o_valid, busy;
  logic [31:0] o_data;
  logic        i_ready16, w_ready16, o_valid16, busy16;
  logic [15:0] o_data16;

  int checks = 0, failures = 0;
  int xm [N][L];
  int wv [N];
  logic [31:0] q [$];

  dcs_gram_attn_core #(.N(N), .L(L), .DW(8), .OW(32)) u_dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .i_ready(i_ready), .mode(mode),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready), .o_valid(o_valid), .o_data(o_data),
    .o_ready(o_ready), .busy(busy));

  dcs_gram_attn_core #(.N(N), .L(L), .DW(8), .OW(16)) u_w16 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .i_ready(i_ready16), .mode(mode),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready16), .o_valid(o_valid16), .o_data(o_data16),
    .o_ready(o_ready), .busy(busy16));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // monitor: every presented beat must equal the scoreboard head, held until handshake
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst && o_valid) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out got=%0d", o_data);
      end else begin
        e = q[0];
        if (o_data !== e) begin
          failures++;
          $display("FAIL y32 got=%0d exp=%0d", o_data, e);
        end
        checks++;
        if (o_data16 !== e[15:0] || o_valid16 !== 1'b1) begin
          failures++;
          $display("FAIL y16 got=%0d exp=%0d", o_data16, e[15:0]);
        end
        if (o_ready) void'(q.pop_front());
      end
    end
  end

  function automatic void push_model(input bit md);
    longint h [N][N];
    longint s, y;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        h[i][j] = 0;
        for (int c = 0; c < L; c++) h[i][j] += longint'(xm[i][c]) * xm[j][c];
      end
    if (!md)
      for (int i = 0; i < N; i++) begin
        s = 0;
        for (int j = 0; j < N; j++) s += h[i][j];
        s = s / N;
        for (int j = 0; j < N; j++) if (h[i][j] < s) h[i][j] = 0;
      end
    for (int i = 0; i < N; i++) begin
      y = 0;
      for (int k = 0; k < N; k++) y += h[i][k] * wv[k];
      q.push_back(32'(y));
    end
  endfunction

  task automatic frame(input int pat, input bit md, input bit tog, input int gap,
                       input int stall, input int rst_out, input int abort_n);
    int n, cyc, hs, st;
    bit first;
    for (int i = 0; i < N; i++) begin
      for (int c = 0; c < L; c++)
        xm[i][c] = pat == 0 ? 1 : pat == 1 ? i + 1 : pat == 2 ? 255 : int'($urandom_range(255));
      wv[i] = pat == 0 ? i + 1 : pat == 1 ? 1 : pat == 2 ? 255 : int'($urandom_range(255));
    end
    n = 0;
    while (n < N * L && n != abort_n) begin
      @(posedge clk); #1;
      i_valid = $urandom_range(99) >= gap;
      i_data  = i_valid ? 8'(xm[n / L][n % L]) : 8'($urandom);
      mode    = (n == 0 || !tog) ? md : ~md;
      @(negedge clk);
      if (i_valid && i_ready) n++;
    end
    @(posedge clk); #1;
    i_valid = 0;
    if (n == abort_n) begin
      rst = 1; #1;
      chk("abort_busy", busy, 0);
      chk("abort_i_ready", i_ready, 1);
      @(posedge clk); #1;
      rst = 0;
      return;
    end
    push_model(md);
    @(negedge clk);
    chk("flush_w_ready", w_ready, 0);
    chk("flush_i_ready", i_ready, 0);
    chk("flush_busy", busy, 1);
    @(negedge clk);
    chk("thresh_w_ready", w_ready, 0);
    @(negedge clk);
    chk("wgt_w_ready", w_ready, 1);
    n = 0;
    cyc = 0;
    while (n < N && cyc < 500) begin
      @(posedge clk); #1;
      w_valid = $urandom_range(99) >= gap;
      w_data  = w_valid ? 8'(wv[n]) : 8'($urandom);
      @(negedge clk);
      if (w_valid && w_ready) n++;
      cyc++;
    end
    if (n < N) chk("w_timeout", n, N);
    hs = 0; st = 0; cyc = 0; first = 1;
    while (hs < N && cyc < 500) begin
      @(posedge clk); #1;
      w_valid = 0;
      o_ready = !(hs == stall && st < 3);
      if (hs == rst_out) begin
        rst = 1; #1;
        chk("rst_out_o_valid", o_valid, 0);
        chk("rst_out_o_data", o_data, 0);
        chk("rst_out_busy", busy, 0);
        q.delete();
        @(posedge clk); #1;
        rst = 0;
        o_ready = 0;
        return;
      end
      @(negedge clk);
      if (first) chk("o_valid_latency", o_valid, 1);
      first = 0;
      if (o_valid && o_ready) hs++;
      else if (o_valid && hs == stall) st++;
      cyc++;
    end
    chk("handshakes", hs, N);
    if (stall >= 0) chk("stall_cycles", st, 3);
    @(posedge clk); #1;
    o_ready = 0;
    @(negedge clk);
    chk("end_i_ready", i_ready, 1);
    chk("end_o_valid", o_valid, 0);
    chk("end_o_data", o_data, 0);
    chk("end_busy", busy, 0);
    chk("scoreboard_empty", q.size(), 0);
  endtask

  initial begin
    #12;
    chk("rst_i_ready", i_ready, 1);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_data", o_data, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 0;
    frame(0, 0, 0, 0, -1, -1, -1);
    frame(1, 0, 0, 0, -1, -1, -1);
    frame(1, 1, 1, 0, -1, -1, -1);
    frame(2, 0, 0, 0, -1, -1, -1);
    frame(3, 0, 0, 30, 2, -1, -1);
    for (int f = 0; f < 4; f++) frame(3, 1'($urandom_range(1)), 1, 25, 2, -1, -1);
    frame(3, 0, 0, 0, -1, -1, 50);
    frame(1, 0, 0, 0, -1, -1, -1);
    frame(3, 0, 0, 10, -1, 2, -1);
    frame(3, 1, 0, 10, 2, -1, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dcs_gram_attn_core.md
Name: dcs_gram_attn_core

Overview:
- Parametrised successor of the fixed 8x16 Gram/attention datapath.
- Streams in an N x L input matrix X (row-major) and accumulates the Gram matrix H = X·Xᵀ on the fly.
- Applies an optional per-row average threshold (mode), then consumes an N-entry weight vector and returns y = H·w as N output beats.
- Adds input/output handshakes (i_ready, o_ready back-pressure) and a runtime threshold-bypass mode, neither of which the fixed-size generation has.

Parameters:
- N, 8, matrix rows, weight length and output beat count; must be a power of two, 2..16.
- L, 16, columns per row (reduction length), 1..64.
- DW, 8, unsigned input and weight width.
- OW, 32, output width; results wrap modulo 2^OW.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  input beat valid.
- i_data  in  DW  X element, row-major: row r, column c = beat r*L+c.
- i_ready  out  1  core accepts X beats.
- mode  in  1  0 = row-average threshold, 1 = bypass; sampled on the first accepted X beat.
- w_valid  in  1  weight beat valid.
- w_data  in  DW  weight w[k], k = 0..N-1 in order.
- w_ready  out  1  core accepts weight beats.
- o_valid  out  1  output beat valid.
- o_data  out  OW  y[i], i = 0..N-1 in order.
- o_ready  in  1  consumer accepts output beat.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, any state): state=IDLE; H, y, counters and mode register cleared. Outputs: i_ready=1, w_ready=0, o_valid=0, o_data=0, busy=0.
- Beat acceptance: an X beat is accepted when i_valid&&i_ready, a weight beat when w_valid&&w_ready, and an output beat when o_valid&&o_ready. Valid without ready is ignored, with no state change.
- States: IDLE, LOAD, FLUSH, THRESH, WGT, OUT.
- IDLE -> LOAD on the first accepted X beat; busy=1 from the next cycle.
- LOAD:
  - Stores X[r][c]. Gaps in i_valid are allowed.
  - Accumulation is registered one cycle after the beat: for every j<=r, H[r][j] += X[r][c]·X[j][c], and the result is mirrored into H[j][r].
  - i_ready drops the cycle after the N*L-th beat.
- FLUSH: one cycle, completes the last pending accumulation.
- THRESH: one cycle.
  - avg[i] = floor(sum_j H[i][j] / N), implemented as a shift.
  - mode=0: H[i][j] <= (H[i][j] < avg[i]) ? 0 : H[i][j]. Equality keeps the value.
  - mode=1: H is unchanged.
- WGT:
  - w_ready=1 from the cycle after THRESH.
  - Each accepted beat k does y[i] += H[i][k]·w_data for all i.
  - After the N-th beat, w_ready=0 on the next cycle and the state moves to OUT.
- OUT:
  - o_valid=1 with o_data=y[0] on the first OUT cycle.
  - On each output handshake o_data advances to the next y[i].
  - While o_ready=0, o_valid and o_data hold stable.
  - After the N-th handshake: o_valid=0, o_data=0, H and y cleared, state=IDLE, i_ready=1 on the next cycle.
- Latency: the last X beat is accepted at edge E; w_ready is high from E+3. The N-th weight is accepted at edge F; o_valid is high from F+1.
- Widths:
  - H entries are 2*DW+clog2(L) bits and never overflow.
  - y is computed at full width, then truncated to OW bits (modulo 2^OW).
  - All arithmetic is unsigned.
- Single-frame core: no overlap between frames. i_ready=0 outside IDLE/LOAD.
- mode changes after the first X beat have no effect until the next frame.
- Reset mid-frame aborts the frame. The next accepted X beat starts a new row 0, column 0.

Test Plan:
- All X=1 (N=8, L=16, mode=0), w=1..8: H all 16, avg 16, nothing zeroed; 8 beats of y=576.
- Row i filled with (i+1), mode=0, w all 1: H[i][j]=16(i+1)(j+1), avg=72(i+1), columns 0..3 zeroed. y[i]=416(i+1), i.e. 416, 832, ... 3328.
- Same X, mode=1, w all 1: y[i]=576(i+1), i.e. 576 ... 4608. mode toggled mid-LOAD is ignored.
- All X=255 and w=255, mode=0: y[i]=2,122,416,000 each. Also check y wraps mod 2^OW with OW=16.
- Random i_valid gaps, and o_ready low for 3 cycles on beat 2: o_data stays y[2] throughout the stall. Exactly 8 handshakes occur, then i_ready=1.
- rst pulsed at beat 50 of LOAD and then a full frame sent: results match a clean frame. A reset during OUT drops o_valid immediately.
